// File: rtl/fifo_read_adapter.sv
// Purpose: drains sync_fifo's request/response read port into a valid/ready stream (optional stats: FIFO_READ_ADAPTER_STATS_EN).
// Latency: read issued in cycle t, word captured at end of t+1, o_VALID in t+2; 1 word/cycle sustained.
// Backpressure: reads issue only while the 2-entry buffer can absorb all in-flight words; output held while stalled.
module fifo_read_adapter #(
  parameter int p_DATA_WIDTH = 8
) (
  input  logic                    i_CLK,
  input  logic                    i_RESET_N,
  input  logic                    i_FIFO_EMPTY,
  input  logic                    i_FIFO_ALMOST_EMPTY,
  input  logic [p_DATA_WIDTH-1:0] i_FIFO_DATA,
  output logic                    o_FIFO_READ_REQUEST,
  output logic                    o_VALID,
  input  logic                    i_READY,
  output logic [p_DATA_WIDTH-1:0] o_DATA
`ifdef FIFO_READ_ADAPTER_STATS_EN
  ,
  output logic [15:0]             o_BEAT_COUNT,
  output logic [15:0]             o_STALL_COUNT
`endif
);

  logic [1:0]              r_COUNT;
  logic                    r_INFLIGHT;
  logic [p_DATA_WIDTH-1:0] r_BUF [0:1];
  logic                    r_HEAD;
  logic                    r_TAIL;

  logic                    w_POP;
  logic                    w_PUSH;
  logic [2:0]              w_CREDIT;
  logic                    w_CREDIT_OK;
  logic                    w_FLAG_OK;

  assign o_VALID = (r_COUNT != 2'd0);
  assign o_DATA  = r_BUF[r_HEAD];
  assign w_POP   = o_VALID & i_READY;
  assign w_PUSH  = r_INFLIGHT;

  // Occupancy the buffer would hold after this edge if nothing new were requested.
  // w_POP implies r_COUNT >= 1, so this never underflows.
  assign w_CREDIT    = {1'b0, r_COUNT} + {2'b00, r_INFLIGHT} - {2'b00, w_POP};
  assign w_CREDIT_OK = (w_CREDIT < 3'd2);

  // FIFO flags lag its occupancy by one cycle: with a read already in flight the
  // empty flag may be stale, so the almost-empty flag must also be clear.
  assign w_FLAG_OK = ~i_FIFO_EMPTY & (~r_INFLIGHT | ~i_FIFO_ALMOST_EMPTY);

  // Gated by reset so the strobe drops immediately on assertion.
  assign o_FIFO_READ_REQUEST = w_CREDIT_OK & w_FLAG_OK & i_RESET_N;

  // Occupancy, in-flight marker and ring pointers.
  always_ff @(posedge i_CLK or negedge i_RESET_N) begin
    if (!i_RESET_N) begin
      r_COUNT    <= 2'd0;
      r_INFLIGHT <= 1'b0;
      r_HEAD     <= 1'b0;
      r_TAIL     <= 1'b0;
    end else begin
      r_COUNT    <= r_COUNT + {1'b0, w_PUSH} - {1'b0, w_POP};
      r_INFLIGHT <= o_FIFO_READ_REQUEST;
      if (w_POP)  r_HEAD <= ~r_HEAD;
      if (w_PUSH) r_TAIL <= ~r_TAIL;
    end
  end

  // Capture the FIFO's registered output the cycle after each read; cleared on
  // reset so o_DATA reads zero while reset is held.
  always_ff @(posedge i_CLK or negedge i_RESET_N) begin
    if (!i_RESET_N) begin
      r_BUF[0] <= '0;
      r_BUF[1] <= '0;
    end else if (w_PUSH) begin
      r_BUF[r_TAIL] <= i_FIFO_DATA;
    end
  end

`ifdef FIFO_READ_ADAPTER_STATS_EN
  logic [15:0] r_BEAT_COUNT;
  logic [15:0] r_STALL_COUNT;

  // Saturating counters of accepted beats and consumer-stall cycles.
  always_ff @(posedge i_CLK or negedge i_RESET_N) begin
    if (!i_RESET_N) begin
      r_BEAT_COUNT  <= 16'd0;
      r_STALL_COUNT <= 16'd0;
    end else begin
      if (w_POP && (r_BEAT_COUNT != 16'hFFFF))
        r_BEAT_COUNT <= r_BEAT_COUNT + 16'd1;
      if (o_VALID && !i_READY && (r_STALL_COUNT != 16'hFFFF))
        r_STALL_COUNT <= r_STALL_COUNT + 16'd1;
    end
  end

  assign o_BEAT_COUNT  = r_BEAT_COUNT;
  assign o_STALL_COUNT = r_STALL_COUNT;
`endif

endmodule
